// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: IF-stage FSM encoding, bus widths and the
// default NOP word used to fill empty pipeline slots.
package cpu_pkg;

  typedef enum logic [1:0] {
    IfStateIdle   = 2'd0,
    IfStateReq    = 2'd1,
    IfStateAccess = 2'd2
  } if_state_e;

  localparam int unsigned WordAddrW = 30;
  localparam int unsigned WordDataW = 32;

  localparam logic [31:0] NopInsnDefault = 32'h0000_0000;

endpackage

// File: rtl/if_reg.sv
// IF/ID pipeline register: flush beats stall beats load. An unstalled cycle
// with nothing to load leaves a bubble so ID never sees a word twice.
module if_reg #(
  parameter int unsigned       ADDR_W       = 30,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSN     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              load,
  input  logic [ADDR_W-1:0] ld_pc,
  input  logic [DATA_W-1:0] ld_insn,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] insn_q, insn_d;
  logic              en_q, en_d;

  always_comb begin
    pc_d   = pc_q;
    insn_d = insn_q;
    en_d   = en_q;
    if (flush) begin
      insn_d = NOP_INSN;
      en_d   = 1'b0;
    end else if (!stall) begin
      if (load) begin
        pc_d   = ld_pc;
        insn_d = ld_insn;
        en_d   = 1'b1;
      end else begin
        insn_d = NOP_INSN;
        en_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      insn_q <= NOP_INSN;
      en_q   <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      insn_q <= insn_d;
      en_q   <= en_d;
    end
  end

  assign if_pc   = pc_q;
  assign if_insn = insn_q;
  assign if_en   = en_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs the fetch bus handshake and feeds
// the IF/ID register. A one-entry hold buffer catches a word that lands during a stall.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W       = WordAddrW,
  parameter int unsigned       DATA_W       = WordDataW,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0] NOP_INSN     = DATA_W'(NopInsnDefault)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_as,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_valid_q, hold_valid_d;
  logic              discard_q, discard_d;

  logic              avail;
  logic              deliver;
  logic [DATA_W-1:0] word;

  always_comb begin
    avail   = hold_valid_q || (state_q == IfStateAccess && bus_rdy && !discard_q);
    word    = hold_valid_q ? hold_data_q : bus_rd_data;
    deliver = avail && !stall && !flush;

    // pc always names the next word to deliver; a taken branch keeps the
    // word delivered alongside it (delay slot).
    pc_d = pc_q;
    if (flush)        pc_d = new_pc;
    else if (deliver) pc_d = br_taken ? br_addr : pc_q + ADDR_W'(1);

    state_d      = state_q;
    bus_addr_d   = bus_addr_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q && !(flush || deliver);
    discard_d    = discard_q;

    case (state_q)
      IfStateIdle: begin
        if (flush || !stall) state_d = IfStateReq;
      end
      IfStateReq: begin
        if (bus_gnt) begin
          state_d    = IfStateAccess;
          bus_addr_d = pc_d;
        end
      end
      IfStateAccess: begin
        if (bus_rdy) begin
          discard_d = 1'b0;
          if (stall && !flush && !discard_q) begin
            hold_data_d  = bus_rd_data;
            hold_valid_d = 1'b1;
            state_d      = IfStateIdle;
          end else begin
            bus_addr_d = pc_d;
          end
        end else if (flush) begin
          // The bus cycle cannot be cancelled; drop its data when it lands.
          discard_d = 1'b1;
        end
      end
      default: state_d = IfStateReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IfStateReq;
      pc_q         <= RESET_VECTOR;
      bus_addr_q   <= RESET_VECTOR;
      hold_data_q  <= NOP_INSN;
      hold_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      bus_addr_q   <= bus_addr_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      discard_q    <= discard_d;
    end
  end

  assign bus_req  = (state_q != IfStateIdle);
  assign bus_as   = (state_q == IfStateAccess);
  assign bus_addr = bus_addr_q;
  assign busy     = !avail;

  if_reg #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RESET_VECTOR(RESET_VECTOR),
    .NOP_INSN    (NOP_INSN)
  ) u_if_reg (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .stall  (stall),
    .load   (avail),
    .ld_pc  (pc_q),
    .ld_insn(word),
    .if_pc  (if_pc),
    .if_insn(if_insn),
    .if_en  (if_en)
  );

endmodule
